// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle restoring divider.
package div_pkg;

    localparam int DIV_DATA_W = 32;  // operand width
    localparam int DIV_CNT_W  = 6;   // iteration counter width, must hold DIV_DATA_W

    // Handshake encodings used by EX and the divider
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_ANNUL            = 1'b1;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'd0,
        DIV_BYZERO = 2'd1,
        DIV_ON     = 2'd2,
        DIV_END    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_if.sv
// EX <-> divider handshake: operands and strobes in, {remainder, quotient} and ready out.
interface div_if
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
);

    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;

    // EX stage side
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    // Divider side
    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic              dvd_msb_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic              q_bit_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // The remainder is always below the divisor, so the shifted value is below twice the
    // divisor and the DATA_W+1-bit difference never overflows: its MSB is a valid sign.
    assign shifted = {rem_i, dvd_msb_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_bit_o = ~diff[DATA_W];
    assign rem_o   = q_bit_o ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div.sv
// Multi-cycle restoring divider (DIV/DIVU) feeding HI/LO: one quotient bit per clock.
module div
    import div_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    div_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;        // partial remainder, final remainder in END
    logic [DATA_W-1:0]   dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
    logic [DATA_W-1:0]   dsr_q, dsr_d;        // divisor magnitude
    logic                neg_quot_q, neg_quot_d;
    logic                neg_rem_q, neg_rem_d;
    logic                ready_q, ready_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0]   op1_mag, op2_mag;
    logic [DATA_W-1:0]   step_rem;
    logic                step_q;
    logic [DATA_W-1:0]   quot_next;

    // Signed operations work on magnitudes; signs are restored after the last step.
    assign op1_mag = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign op2_mag = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[DATA_W-1]),
        .divisor_i (dsr_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    assign quot_next = {dvd_q[DATA_W-2:0], step_q};

    // Next-state, datapath and registered-output logic for the FREE/BYZERO/ON/END machine.
    always_comb begin
        // NOTE: every signal gets a default first so no branch leaves one unassigned and infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ready_d    = DIV_RESULT_NOT_READY;
        result_d   = '0;

        unique case (state_q)
            DIV_FREE: begin
                if (bus.start_i == DIV_START && bus.annul_i != DIV_ANNUL) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d    = DIV_ON;
                        rem_d      = '0;
                        dvd_d      = op1_mag;
                        dsr_d      = op2_mag;
                        neg_quot_d = bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
                        neg_rem_d  = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
                        cnt_d      = '0;
                    end
                end
            end
            DIV_BYZERO: begin
                if (bus.annul_i == DIV_ANNUL) begin
                    state_d = DIV_FREE;
                end else begin
                    state_d = DIV_END;
                    rem_d   = '0;
                    dvd_d   = '0;
                end
            end
            DIV_ON: begin
                if (bus.annul_i == DIV_ANNUL) begin
                    state_d = DIV_FREE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DIV_END;
                        rem_d   = neg_rem_q  ? -step_rem  : step_rem;
                        dvd_d   = neg_quot_q ? -quot_next : quot_next;
                    end else begin
                        rem_d = step_rem;
                        dvd_d = quot_next;
                    end
                end
            end
            DIV_END: begin
                if (bus.start_i == DIV_STOP) begin
                    state_d = DIV_FREE;
                end else begin
                    ready_d  = DIV_RESULT_READY;
                    result_d = {rem_q, dvd_q};
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    // Control state and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= DIV_FREE;
            cnt_q    <= '0;
            ready_q  <= DIV_RESULT_NOT_READY;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are always loaded at acceptance before anything reads them.
        rem_q      <= rem_d;
        dvd_q      <= dvd_d;
        dsr_q      <= dsr_d;
        neg_quot_q <= neg_quot_d;
        neg_rem_q  <= neg_rem_d;
    end

    assign bus.ready_o  = ready_q;
    assign bus.result_o = result_q;

endmodule
